reg_file_sb: RTL

// - Next-generation register file for the FASA datapath: 2**A x W registers.
// - Two combinational read ports with write-first bypass.
// - Three write sources: ALU result, load-immediate into a dedicated register, and a late-returning memory load.
// - A one-entry load scoreboard flags read-after-load hazards so the controller can stall.

---
 rtl/reg_file_sb_if.sv | 35 +++
 rtl/reg_file_sb.sv | 129 ++++++++++++
 2 files changed

// File: rtl/reg_file_sb_if.sv
// Bus bundle for reg_file_sb: read ports, the three write sources and load scoreboard status.
// The controller side uses the master modport; the register file uses the slave modport.
interface reg_file_sb_if #(
  parameter int unsigned W = 8,
  parameter int unsigned A = 4
);
  logic [A-1:0] RaddrA;
  logic [A-1:0] RaddrB;
  logic [W-1:0] DataOutA;
  logic [W-1:0] DataOutB;
  logic         AluWen;
  logic [A-1:0] AluWaddr;
  logic [W-1:0] AluWdata;
  logic         ImmWen;
  logic [W-1:0] ImmData;
  logic         LdIssue;
  logic [A-1:0] LdDest;
  logic         LdValid;
  logic [W-1:0] LdData;
  logic         LdBusy;
  logic         HazA;
  logic         HazB;

  modport master (
    output RaddrA, RaddrB, AluWen, AluWaddr, AluWdata, ImmWen, ImmData,
    output LdIssue, LdDest, LdValid, LdData,
    input  DataOutA, DataOutB, LdBusy, HazA, HazB
  );

  modport slave (
    input  RaddrA, RaddrB, AluWen, AluWaddr, AluWdata, ImmWen, ImmData,
    input  LdIssue, LdDest, LdValid, LdData,
    output DataOutA, DataOutB, LdBusy, HazA, HazB
  );
endinterface

// File: rtl/reg_file_sb.sv
// 2**A x W register file with write-first bypass, three write sources and a one-entry load
// scoreboard. Define REGFILE_ZERO_REG_EN to hard-wire r0 to zero.
module reg_file_sb #(
  parameter int unsigned W       = 8,
  parameter int unsigned A       = 4,
  parameter int unsigned IMM_REG = 3
) (
  input logic          Clk,
  input logic          Reset,
  reg_file_sb_if.slave bus
);

  localparam int unsigned  Depth   = 1 << A;
  localparam logic [A-1:0] ImmAddr = A'(IMM_REG);
`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZeroRegEn = 1'b1;
`else
  localparam bit ZeroRegEn = 1'b0;
`endif

  typedef enum logic [0:0] {StIdle, StPend} state_e;

  state_e         state_q, state_d;
  logic [A-1:0]   pend_addr_q, pend_addr_d;
  logic [W-1:0]   regs_q [Depth];
  logic [W-1:0]   regs_d [Depth];
  logic           pend_vld;
  logic           ld_wr;

  logic [A-1:0]   raddr_a, raddr_b, alu_waddr, ld_dest;
  logic [W-1:0]   alu_wdata, imm_data, ld_data;
  logic           alu_wen, imm_wen, ld_issue, ld_valid;

  assign raddr_a   = bus.RaddrA;
  assign raddr_b   = bus.RaddrB;
  assign alu_wen   = bus.AluWen;
  assign alu_waddr = bus.AluWaddr;
  assign alu_wdata = bus.AluWdata;
  assign imm_wen   = bus.ImmWen;
  assign imm_data  = bus.ImmData;
  assign ld_issue  = bus.LdIssue;
  assign ld_dest   = bus.LdDest;
  assign ld_valid  = bus.LdValid;
  assign ld_data   = bus.LdData;

  assign pend_vld = (state_q == StPend);

  // Single outstanding load: a new issue is only accepted when idle or as the pending one returns.
  always_comb begin
    state_d     = state_q;
    pend_addr_d = pend_addr_q;
    ld_wr       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ld_issue) begin
          state_d     = StPend;
          pend_addr_d = ld_dest;
        end
      end
      StPend: begin
        if (ld_valid) begin
          ld_wr = 1'b1;
          if (ld_issue) begin
            pend_addr_d = ld_dest;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Later assignments win: load return > immediate > ALU.
  always_comb begin
    for (int unsigned i = 0; i < Depth; i++) begin
      regs_d[i] = regs_q[i];
      if (!(ZeroRegEn && (i == 0))) begin
        if (alu_wen && (alu_waddr == A'(i))) regs_d[i] = alu_wdata;
        if (imm_wen && (ImmAddr == A'(i)))   regs_d[i] = imm_data;
        if (ld_wr && (pend_addr_q == A'(i))) regs_d[i] = ld_data;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= StIdle;
      pend_addr_q <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      pend_addr_q <= pend_addr_d;
      for (int unsigned i = 0; i < Depth; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  function automatic logic [W-1:0] read_port(input logic [A-1:0] addr);
    logic [W-1:0] val;
    if (ZeroRegEn && (addr == '0)) begin
      val = '0;
    end else if (ld_wr && (addr == pend_addr_q)) begin
      val = ld_data;
    end else if (imm_wen && (addr == ImmAddr)) begin
      val = imm_data;
    end else if (alu_wen && (addr == alu_waddr)) begin
      val = alu_wdata;
    end else begin
      val = regs_q[addr];
    end
    return val;
  endfunction

  // Returning data is bypassed, so no stall is needed in the return cycle.
  function automatic logic hazard(input logic [A-1:0] addr);
    return pend_vld && (addr == pend_addr_q) && !ld_valid && !(ZeroRegEn && (addr == '0));
  endfunction

  assign bus.DataOutA = read_port(raddr_a);
  assign bus.DataOutB = read_port(raddr_b);
  assign bus.HazA     = hazard(raddr_a);
  assign bus.HazB     = hazard(raddr_b);
  assign bus.LdBusy   = pend_vld;

endmodule
